// File: rtl/bp_pkg.sv
// Shared types and constants for the branch_predictor slice.
// The default table layout lives here so that other code can model the predictor.
package bp_pkg;

  localparam int DEF_PC_WIDTH   = 30;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_CTR_WIDTH  = 2;

  localparam logic [31:0] STAT_SAT = 32'hFFFF_FFFF;

  // Weakly taken: MSB set, rest clear. Weakly not-taken: MSB clear, rest set.
  function automatic int weak_taken_val(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int weak_not_taken_val(input int w);
    return weak_taken_val(w) - 1;
  endfunction

  localparam logic [DEF_CTR_WIDTH-1:0] CTR_WEAK_T  = DEF_CTR_WIDTH'(weak_taken_val(DEF_CTR_WIDTH));
  localparam logic [DEF_CTR_WIDTH-1:0] CTR_WEAK_NT = DEF_CTR_WIDTH'(weak_not_taken_val(DEF_CTR_WIDTH));

  typedef struct packed {
    logic                                   valid;
    logic [DEF_PC_WIDTH-DEF_INDEX_BITS-1:0] tag;
    logic [DEF_PC_WIDTH-1:0]                target;
    logic [DEF_CTR_WIDTH-1:0]               ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a saturating up/down direction counter.
module bp_sat_ctr #(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != {CTR_WIDTH{1'b1}})) begin
      ctr_next = ctr + CTR_WIDTH'(1);
    end else if (!taken && (ctr != '0)) begin
      ctr_next = ctr - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters; combinational lookup, EX-stage update.
// Define BP_STATS_EN to build the saturating lookup/mispredict statistics counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int CTR_WIDTH  = DEF_CTR_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic [PC_WIDTH-1:0] i_lookup_pc,
  output logic                o_hit,
  output logic                o_pred_taken,
  output logic [PC_WIDTH-1:0] o_pred_target,
  input  logic                i_inv,
  input  logic                i_upd_valid,
  input  logic [PC_WIDTH-1:0] i_upd_pc,
  input  logic                i_upd_taken,
  input  logic [PC_WIDTH-1:0] i_upd_target,
  input  logic                i_upd_pred_taken,
  input  logic [PC_WIDTH-1:0] i_upd_pred_target,
  output logic                o_mispredict,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [31:0]         o_stat_lookups,
  output logic [31:0]         o_stat_mispredicts
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_WIDTH'(weak_taken_val(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(weak_not_taken_val(CTR_WIDTH));

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_q   [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_d   [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic [CTR_WIDTH-1:0]  ctr_next;

  assign lk_idx = i_lookup_pc[INDEX_BITS-1:0];
  assign lk_tag = i_lookup_pc[PC_WIDTH-1:INDEX_BITS];
  assign up_idx = i_upd_pc[INDEX_BITS-1:0];
  assign up_tag = i_upd_pc[PC_WIDTH-1:INDEX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign o_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign o_pred_taken  = o_hit && ctr_q[lk_idx][CTR_WIDTH-1];
  assign o_pred_target = o_pred_taken ? target_q[lk_idx] : i_lookup_pc + PC_WIDTH'(1);

  assign o_mispredict  = i_upd_valid &&
                         ((i_upd_taken != i_upd_pred_taken) ||
                          (i_upd_taken && (i_upd_target != i_upd_pred_target)));
  assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + PC_WIDTH'(1);

  bp_sat_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_sat_ctr (
    .ctr      (ctr_q[up_idx]),
    .taken    (i_upd_taken),
    .ctr_next (ctr_next)
  );

  // Invalidate wins over a concurrent update; the update's mispredict is still reported.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (i_inv) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (i_upd_valid) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_next;
        if (i_upd_taken) begin
          target_d[up_idx] = i_upd_target;
        end
      end else if (i_upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = i_upd_target;
        ctr_d[up_idx]    = WEAK_T;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q;
  logic [31:0] stat_lookups_d;
  logic [31:0] stat_misp_q;
  logic [31:0] stat_misp_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_misp_d    = stat_misp_q;
    if (stat_lookups_q != STAT_SAT) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
    end
    if (o_mispredict && (stat_misp_q != STAT_SAT)) begin
      stat_misp_d = stat_misp_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      stat_lookups_q <= '0;
      stat_misp_q    <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_misp_q    <= stat_misp_d;
    end
  end

  assign o_stat_lookups     = stat_lookups_q;
  assign o_stat_mispredicts = stat_misp_q;
`else
  assign o_stat_lookups     = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a reference table model feeds a scoreboard queue.
// Stats expectations follow BP_STATS_EN the same way the design does.
`timescale 1ns/1ps
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int PW = DEF_PC_WIDTH;
  localparam int IB = DEF_INDEX_BITS;
  localparam int CW = DEF_CTR_WIDTH;
  localparam int NE = 2 ** IB;

  typedef struct packed {
    logic [PW-1:0] lpc;
    logic          inv;
    logic          uv;
    logic [PW-1:0] upc;
    logic          ut;
    logic [PW-1:0] utgt;
    logic          upt;
    logic [PW-1:0] uptgt;
  } step_t;

  typedef struct packed {
    logic          hit;
    logic          taken;
    logic [PW-1:0] target;
    logic          misp;
    logic [PW-1:0] redirect;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic [PW-1:0] i_lookup_pc;
  logic          o_hit;
  logic          o_pred_taken;
  logic [PW-1:0] o_pred_target;
  logic          i_inv;
  logic          i_upd_valid;
  logic [PW-1:0] i_upd_pc;
  logic          i_upd_taken;
  logic [PW-1:0] i_upd_target;
  logic          i_upd_pred_taken;
  logic [PW-1:0] i_upd_pred_target;
  logic          o_mispredict;
  logic [PW-1:0] o_redirect_pc;
  logic [31:0]   o_stat_lookups;
  logic [31:0]   o_stat_mispredicts;

  exp_t      sb [$];
  bp_entry_t model [NE];
  step_t     cur;
  exp_t      obs;
  exp_t      exp_v;
  int        checks = 0;
  int        errors = 0;

  branch_predictor dut (
    .i_clk             (clk),
    .i_nrst            (nrst),
    .i_lookup_pc       (i_lookup_pc),
    .o_hit             (o_hit),
    .o_pred_taken      (o_pred_taken),
    .o_pred_target     (o_pred_target),
    .i_inv             (i_inv),
    .i_upd_valid       (i_upd_valid),
    .i_upd_pc          (i_upd_pc),
    .i_upd_taken       (i_upd_taken),
    .i_upd_target      (i_upd_target),
    .i_upd_pred_taken  (i_upd_pred_taken),
    .i_upd_pred_target (i_upd_pred_target),
    .o_mispredict      (o_mispredict),
    .o_redirect_pc     (o_redirect_pc),
    .o_stat_lookups    (o_stat_lookups),
    .o_stat_mispredicts(o_stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic step_t st(input logic [PW-1:0] lpc, input logic inv, input logic uv,
                               input logic [PW-1:0] upc, input logic ut, input logic [PW-1:0] utgt,
                               input logic upt, input logic [PW-1:0] uptgt);
    step_t s;
    s.lpc = lpc; s.inv = inv; s.uv = uv; s.upc = upc;
    s.ut = ut; s.utgt = utgt; s.upt = upt; s.uptgt = uptgt;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      model[i] = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
    end
  endtask

  function automatic exp_t model_expect(input step_t s);
    bp_entry_t e;
    exp_t      r;
    e          = model[s.lpc[IB-1:0]];
    r.hit      = e.valid && (e.tag == s.lpc[PW-1:IB]);
    r.taken    = r.hit && e.ctr[CW-1];
    r.target   = r.taken ? e.target : s.lpc + PW'(1);
    r.misp     = s.uv && ((s.ut != s.upt) || (s.ut && (s.utgt != s.uptgt)));
    r.redirect = s.ut ? s.utgt : s.upc + PW'(1);
    return r;
  endfunction

  task automatic model_update(input step_t s);
    logic [IB-1:0] idx;
    idx = s.upc[IB-1:0];
    if (s.inv) begin
      for (int i = 0; i < NE; i++) model[i].valid = 1'b0;
    end else if (s.uv) begin
      if (model[idx].valid && (model[idx].tag == s.upc[PW-1:IB])) begin
        if (s.ut) begin
          if (model[idx].ctr != {CW{1'b1}}) model[idx].ctr = model[idx].ctr + CW'(1);
          model[idx].target = s.utgt;
        end else if (model[idx].ctr != '0) begin
          model[idx].ctr = model[idx].ctr - CW'(1);
        end
      end else if (s.ut) begin
        model[idx] = '{valid: 1'b1, tag: s.upc[PW-1:IB], target: s.utgt, ctr: CTR_WEAK_T};
      end
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be before the next edge.
  task automatic drive(input step_t s);
    cur               = s;
    i_lookup_pc       = s.lpc;
    i_inv             = s.inv;
    i_upd_valid       = s.uv;
    i_upd_pc          = s.upc;
    i_upd_taken       = s.ut;
    i_upd_target      = s.utgt;
    i_upd_pred_taken  = s.upt;
    i_upd_pred_target = s.uptgt;
    sb.push_back(model_expect(s));
  endtask

  task automatic advance();
    @(posedge clk);
    if (nrst) model_update(cur);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    drive(st(30'h10, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0));
    #2;
    exp_v = sb.pop_front();
    obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_lookup: {hit,taken,target,misp,redirect} got %h expected %h", obs, exp_v);
    end
    checks++;
    if (o_hit !== 1'b0 || o_pred_taken !== 1'b0 || o_pred_target !== 30'h11) begin
      errors++;
      $display("[TB] FAIL reset_literal: hit=%0b taken=%0b target=%h expected 0 0 11", o_hit, o_pred_taken, o_pred_target);
    end
    checks++;
    if (o_stat_lookups !== 32'd0 || o_stat_mispredicts !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", o_stat_lookups, o_stat_mispredicts);
    end
    advance();
    nrst = 1'b1;
  endtask

  task automatic test_alloc();
    step_t s [2];
    s[0] = st(30'h10, 1'b0, 1'b1, 30'h10, 1'b1, 30'h40, 1'b0, 30'h0);
    s[1] = st(30'h10, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL alloc[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      checks++;
      if (i == 0 && (o_mispredict !== 1'b1 || o_redirect_pc !== 30'h40)) begin
        errors++;
        $display("[TB] FAIL alloc_misp: misp=%0b redirect=%h expected 1 40", o_mispredict, o_redirect_pc);
      end else if (i == 1 && (o_hit !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 30'h40)) begin
        errors++;
        $display("[TB] FAIL alloc_hit: hit=%0b taken=%0b target=%h expected 1 1 40", o_hit, o_pred_taken, o_pred_target);
      end
      advance();
    end
  endtask

  task automatic test_counter();
    // Per step: 0 = lookup only, 1 = taken update, 2 = not-taken update; lit = required pred_taken or -1.
    int kind [12] = '{2, 2, 2, 0, 1, 0, 1, 1, 1, 1, 2, 0};
    int lit  [12] = '{-1, -1, -1, 0, -1, 0, -1, -1, -1, -1, -1, 1};
    for (int i = 0; i < 12; i++) begin
      drive(st(30'h10, 1'b0, kind[i] != 0, 30'h10, kind[i] == 1, 30'h40, 1'b0, 30'h0));
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL counter[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      if (lit[i] >= 0) begin
        checks++;
        if (o_pred_taken !== lit[i][0]) begin
          errors++;
          $display("[TB] FAIL counter_sat[%0d]: pred_taken got %0b expected %0d", i, o_pred_taken, lit[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_alias();
    step_t s [3];
    s[0] = st(30'h10, 1'b0, 1'b1, 30'h20, 1'b1, 30'h55, 1'b0, 30'h0);
    s[1] = st(30'h10, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    s[2] = st(30'h20, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL alias[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      checks++;
      if (i == 1 && o_hit !== 1'b0) begin
        errors++;
        $display("[TB] FAIL alias_old_miss: hit got %0b expected 0", o_hit);
      end else if (i == 2 && (o_hit !== 1'b1 || o_pred_target !== 30'h55)) begin
        errors++;
        $display("[TB] FAIL alias_new_hit: hit=%0b target=%h expected 1 55", o_hit, o_pred_target);
      end
      advance();
    end
  endtask

  task automatic test_miss_nt();
    step_t s [3];
    s[0] = st(30'h33, 1'b0, 1'b1, 30'h33, 1'b0, 30'h0, 1'b1, 30'h12);
    s[1] = st(30'h33, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    s[2] = st(30'h3FFF_FFFF, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0, 30'h0, 1'b0, 30'h0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL miss_nt[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      if (i == 2) begin
        checks++;
        if (o_redirect_pc !== 30'h0 || o_pred_target !== 30'h0 || o_mispredict !== 1'b0) begin
          errors++;
          $display("[TB] FAIL pc_wrap: redirect=%h target=%h misp=%0b expected 0 0 0", o_redirect_pc, o_pred_target, o_mispredict);
        end
      end
      advance();
    end
  endtask

  task automatic test_inv();
    step_t s [5];
    s[0] = st(30'h35, 1'b0, 1'b1, 30'h35, 1'b1, 30'h77, 1'b0, 30'h0);
    s[1] = st(30'h35, 1'b1, 1'b1, 30'h30, 1'b1, 30'h70, 1'b0, 30'h0);
    s[2] = st(30'h30, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    s[3] = st(30'h20, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    s[4] = st(30'h35, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL inv[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      checks++;
      if (i == 1 && (o_mispredict !== 1'b1 || o_hit !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL inv_same_cycle: misp=%0b hit=%0b expected 1 1", o_mispredict, o_hit);
      end else if (i >= 2 && o_hit !== 1'b0) begin
        errors++;
        $display("[TB] FAIL inv_empty[%0d]: hit got %0b expected 0", i, o_hit);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    for (int i = 0; i < 60; i++) begin
      s.lpc   = PW'($urandom_range(0, 63));
      s.inv   = ($urandom_range(0, 15) == 0);
      s.uv    = 1'($urandom_range(0, 1));
      s.upc   = PW'($urandom_range(0, 63));
      s.ut    = 1'($urandom_range(0, 1));
      s.utgt  = PW'($urandom);
      s.upt   = 1'($urandom_range(0, 1));
      s.uptgt = ($urandom_range(0, 1) == 1) ? s.utgt : PW'($urandom);
      drive(s);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(st(30'h15, 1'b0, 1'b1, 30'h15, 1'b1, 30'h99, 1'b0, 30'h0));
    #2;
    exp_v = sb.pop_front();
    obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_mid_upd: {hit,taken,target,misp,redirect} got %h expected %h", obs, exp_v);
    end
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 model_reset();
    @(negedge clk);
    nrst = 1'b1;
    drive(st(30'h15, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0));
    #2;
    exp_v = sb.pop_front();
    obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
    checks++;
    if (obs !== exp_v || o_hit !== 1'b0 || o_pred_target !== 30'h16) begin
      errors++;
      $display("[TB] FAIL reset_mid_lost: {hit,taken,target,misp,redirect} got %h expected %h", obs, exp_v);
    end
    advance();
  endtask

  task automatic test_stats();
    step_t s;
    logic [31:0] exp_lk;
    logic [31:0] exp_mp;
    i_upd_valid = 1'b0;
    i_inv       = 1'b0;
    nrst        = 1'b0;
    #3 model_reset();
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      s = st(30'h50, 1'b0, 1'b1, 30'h50, 1'b1, 30'h60, 1'b0, 30'h0);
      else if (i == 6) s = st(30'h50, 1'b0, 1'b1, 30'h50, 1'b1, 30'h60, 1'b1, 30'h61);
      else             s = st(30'h50, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 30'h0);
      drive(s);
      #2;
      exp_v = sb.pop_front();
      obs   = {o_hit, o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL stats_cycle[%0d]: {hit,taken,target,misp,redirect} got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
`ifdef BP_STATS_EN
    exp_lk = 32'd10;
    exp_mp = 32'd2;
`else
    exp_lk = 32'd0;
    exp_mp = 32'd0;
`endif
    checks++;
    if (o_stat_lookups !== exp_lk) begin
      errors++;
      $display("[TB] FAIL stat_lookups: got %0d expected %0d", o_stat_lookups, exp_lk);
    end
    checks++;
    if (o_stat_mispredicts !== exp_mp) begin
      errors++;
      $display("[TB] FAIL stat_mispredicts: got %0d expected %0d", o_stat_mispredicts, exp_mp);
    end
  endtask

  initial begin
    nrst              = 1'b0;
    i_lookup_pc       = '0;
    i_inv             = 1'b0;
    i_upd_valid       = 1'b0;
    i_upd_pc          = '0;
    i_upd_taken       = 1'b0;
    i_upd_target      = '0;
    i_upd_pred_taken  = 1'b0;
    i_upd_pred_target = '0;
    cur               = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_miss_nt();
    test_inv();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
